// File: rtl/cfg_stream_ctrl.sv
// cfg_stream_ctrl
// Master sequencer for the fabric configuration chain. A load command
// (target ID + payload bit length) is turned into one frame on the chain:
// a one-cycle start pulse, the ID header (LSB first), the payload bits
// (LSB of each host word first), then an idle gap that ends with a
// one-cycle done pulse.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready      command handshake; cmd_id, cmd_len latched on accept
//   data_valid/data_ready    payload word handshake; data_word carries the bits
//   cfg_out_start            one-cycle frame start into the chain
//   cfg_bit_out(_valid)      serial config bit and its qualifier
//   busy                     high whenever the sequencer is not idle
//   done                     one-cycle pulse at the end of a frame
//   dbg_state_o              current FSM state, for observation only
//
// Handshakes: a transfer happens on a rising clk edge where valid and
// ready are both high. ready never depends on valid, and a producer
// holding valid is never forced to drop it.
module cfg_stream_ctrl #(
  parameter int ID_WIDTH   = 3,
  parameter int WORD_W     = 32,
  parameter int LEN_W      = 16,
  parameter int GAP_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ID_WIDTH-1:0] cmd_id,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic                data_valid,
  output logic                data_ready,
  input  logic [WORD_W-1:0]   data_word,
  output logic                cfg_out_start,
  output logic                cfg_bit_out,
  output logic                cfg_bit_out_valid,
  output logic                busy,
  output logic                done,
  output logic [2:0]          dbg_state_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_HEADER  = 3'd2;
  localparam logic [2:0] S_PAYLOAD = 3'd3;
  localparam logic [2:0] S_GAP     = 3'd4;

  localparam int BW = $clog2(WORD_W) + 1;
  localparam int HW = $clog2(ID_WIDTH) + 1;
  localparam int GW = $clog2(GAP_CYCLES) + 1;

  logic [2:0]          state_q,   state_d;
  logic [ID_WIDTH-1:0] id_sh_q,   id_sh_d;
  logic [HW-1:0]       hdr_cnt_q, hdr_cnt_d;
  logic [GW-1:0]       gap_cnt_q, gap_cnt_d;
  logic [LEN_W-1:0]    rem_q,     rem_d;
  logic [WORD_W-1:0]   buf_q,     buf_d;
  logic [BW-1:0]       buf_cnt_q, buf_cnt_d;
  logic                start_q,   start_d;
  logic                bit_q,     bit_d;
  logic                valid_q,   valid_d;
  logic                done_q,    done_d;

  logic             emit;
  logic             ready_c;
  logic             load;
  logic [LEN_W-1:0] rem_after;
  logic [BW-1:0]    load_cnt;

  // A payload bit leaves whenever the buffer still holds unsent bits.
  assign emit      = (state_q == S_PAYLOAD) && (buf_cnt_q != '0);
  assign rem_after = rem_q - LEN_W'(emit);

  // Request a word only if bits remain beyond those already buffered, and
  // the buffer is empty or is sending its last bit right now. The second
  // case lets the next word land with no bubble on an unbroken stream.
  assign ready_c = (state_q == S_PAYLOAD) && (rem_q > LEN_W'(buf_cnt_q)) &&
                   ((buf_cnt_q == '0) || ((buf_cnt_q == BW'(1)) && emit));
  assign load    = ready_c && data_valid;

  // A new word only counts the bits still owed; surplus high bits of the
  // final word are never sent.
  assign load_cnt = (rem_after >= LEN_W'(WORD_W)) ? BW'(WORD_W) : BW'(rem_after);

  always_comb begin
    state_d   = state_q;
    id_sh_d   = id_sh_q;
    hdr_cnt_d = hdr_cnt_q;
    gap_cnt_d = gap_cnt_q;
    rem_d     = rem_q;
    buf_d     = buf_q;
    buf_cnt_d = buf_cnt_q;
    start_d   = 1'b0;
    bit_d     = 1'b0;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          id_sh_d   = cmd_id;
          rem_d     = cmd_len;
          hdr_cnt_d = '0;
          buf_cnt_d = '0;
          state_d   = S_START;
        end
      end
      S_START: begin
        start_d = 1'b1;
        state_d = S_HEADER;
      end
      S_HEADER: begin
        bit_d     = id_sh_q[0];
        valid_d   = 1'b1;
        id_sh_d   = id_sh_q >> 1;
        hdr_cnt_d = hdr_cnt_q + HW'(1);
        if (hdr_cnt_q == HW'(ID_WIDTH - 1)) begin
          gap_cnt_d = '0;
          state_d   = (rem_q != '0) ? S_PAYLOAD : S_GAP;
        end
      end
      S_PAYLOAD: begin
        if (emit) begin
          bit_d     = buf_q[0];
          valid_d   = 1'b1;
          buf_d     = buf_q >> 1;
          buf_cnt_d = buf_cnt_q - BW'(1);
          rem_d     = rem_after;
        end
        if (load) begin
          buf_d     = data_word;
          buf_cnt_d = load_cnt;
        end
        if (emit && (rem_q == LEN_W'(1))) begin
          gap_cnt_d = '0;
          state_d   = S_GAP;
        end
      end
      S_GAP: begin
        gap_cnt_d = gap_cnt_q + GW'(1);
        if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      id_sh_q   <= '0;
      hdr_cnt_q <= '0;
      gap_cnt_q <= '0;
      rem_q     <= '0;
      buf_q     <= '0;
      buf_cnt_q <= '0;
      start_q   <= 1'b0;
      bit_q     <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_sh_q   <= id_sh_d;
      hdr_cnt_q <= hdr_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      rem_q     <= rem_d;
      buf_q     <= buf_d;
      buf_cnt_q <= buf_cnt_d;
      start_q   <= start_d;
      bit_q     <= bit_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
    end
  end

  // Outputs are masked while rst is high so the chain and host see a quiet
  // interface during the reset cycle itself, not only after it.
  assign cmd_ready         = (state_q == S_IDLE) && !rst;
  assign data_ready        = ready_c && !rst;
  assign busy              = (state_q != S_IDLE) && !rst;
  assign cfg_out_start     = start_q && !rst;
  assign cfg_bit_out       = bit_q && !rst;
  assign cfg_bit_out_valid = valid_q && !rst;
  assign done              = done_q && !rst;
  assign dbg_state_o       = state_q;

endmodule

// File: doc/cfg_stream_ctrl.md
Name: cfg_stream_ctrl

Overview:
- Master sequencer for the fabric configuration chain.
- Accepts load commands (target ID plus payload bit length) and payload words from the host or bitstream interface.
- Serializes each command into the start, bit and valid protocol that the chained config blocks consume: one start pulse, the target ID header, then the payload bits, then an inter-frame gap.
- Sits between the host/SoC interface and the first config block in the chain.

Parameters:
- ID_WIDTH, 3: width of the target block ID header.
- WORD_W, 32: host payload word width.
- LEN_W, 16: width of the payload bit-length field.
- GAP_CYCLES, 4: idle cycles after the last payload bit, before done and the next frame (must be >= 2).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- cmd_valid  input  1  load command valid
- cmd_ready  output  1  command accepted when valid&ready
- cmd_id  input  ID_WIDTH  target config block ID
- cmd_len  input  LEN_W  payload bit count (the target's CFG_SIZE)
- data_valid  input  1  payload word valid
- data_ready  output  1  payload word accepted when valid&ready
- data_word  input  WORD_W  payload bits, LSB is sent first
- cfg_out_start  output  1  one-cycle frame start into chain
- cfg_bit_out  output  1  serial config bit
- cfg_bit_out_valid  output  1  cfg_bit_out qualifier
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse at end of frame

Behaviour:
- Reset and defaults:
  - rst (sync) forces IDLE, clears all counters and the word buffer.
  - While in reset and on the cycle after: cfg_out_start=0, cfg_bit_out=0, cfg_bit_out_valid=0, busy=0, done=0, data_ready=0.
  - cmd_ready=1 only in IDLE and not in rst.
  - Reset mid-frame aborts with no further bits; the chain recovers on the next cfg_out_start.
- States: IDLE, START, HEADER, PAYLOAD, GAP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch id and len, then -> START.
- START:
  - Exactly one cycle.
  - cfg_out_start=1, cfg_bit_out_valid=0.
  - -> HEADER.
- HEADER:
  - ID_WIDTH consecutive cycles, cfg_bit_out_valid=1.
  - cfg_bit_out = id[k] for k=0..ID_WIDTH-1 (LSB first).
  - After the last ID bit: -> PAYLOAD if len!=0, else -> GAP.
- PAYLOAD:
  - Word buffer with buf_cnt = number of unsent bits in the buffer.
  - rem = payload bits not yet emitted, including buffered bits.
  - A bit is emitted when buf_cnt>0:
    - cfg_bit_out = buffer LSB, cfg_bit_out_valid=1.
    - Buffer shifts right; buf_cnt and rem decrement.
  - When buf_cnt=0, cfg_bit_out_valid=0 (stall bubble) and cfg_bit_out=0.
  - data_ready = PAYLOAD & (rem > buf_cnt) & (buf_cnt==0 | (buf_cnt==1 & a bit is emitted this cycle)).
    - The load overlaps the last bit of the previous word, so an uninterrupted data stream gives no bubble.
  - A loaded word sets buf_cnt = min(WORD_W, rem - bits already committed).
    - Upper unused bits of the final word are discarded.
    - The host supplies exactly ceil(len/WORD_W) words; no extra word is requested.
  - When the bit that makes rem reach 0 is emitted: -> GAP.
- GAP:
  - GAP_CYCLES cycles, all chain outputs 0.
  - On the last gap cycle: done=1, -> IDLE.
  - The earliest next cfg_out_start is 2 cycles after done (IDLE accept, then START).
- Output timing: all chain outputs are registered, so the chain sees them one cycle after the state decision. Cycle counts above refer to the register outputs.
- Edge cases:
  - cmd_valid is ignored outside IDLE.
  - data_valid is ignored unless data_ready.
  - cmd_len=0 produces start plus header only.
  - A data stall of any length only inserts cfg_bit_out_valid=0 cycles. Bit order and count are unchanged.
- Arithmetic widths:
  - rem is LEN_W bits wide.
  - buf_cnt is clog2(WORD_W)+1 bits wide.
  - No wrap-around: rem never decrements below 0.

Test Plan:
- Basic frame:
  - Stimulus: ID_WIDTH=3, WORD_W=32; cmd id=5, len=8; word 0x000000A5 presented immediately.
  - Response: start pulse; header bits 1,0,1; payload bits 1,0,1,0,0,1,0,1 with valid continuous; 4 gap cycles; done; exactly 1 data handshake.
- Partial final word:
  - Stimulus: len=40, words 0xFFFFFFFF then 0x00000003, data_valid held high.
  - Response: 40 valid payload bits, last 8 = 1,1,0,0,0,0,0,0; no bubble at the word boundary; exactly 2 data handshakes, and data_ready stays 0 afterwards.
- Data stall:
  - Stimulus: len=8; data_valid held low for 5 cycles after entering PAYLOAD.
  - Response: 5 cycles with valid=0; same bit sequence as the basic frame; done timing shifted by 5 cycles.
- Zero length:
  - Stimulus: cmd id=2, len=0.
  - Response: start, header 0,1,0, gap, done; data_ready never asserts.
- Reset mid-payload:
  - Stimulus: assert rst after 3 payload bits.
  - Response: next cycle all outputs 0, busy=0, cmd_ready=1 after rst deasserts; no done pulse.
- Back-to-back commands:
  - Stimulus: cmd_valid held with two commands.
  - Response: second cfg_out_start exactly 2 cycles after the first done; cmd_ready low throughout the first frame.
